// File: rtl/lfsr_scrambler_param.sv
// ---------------------------------------------------------------------------
// lfsr_scrambler_param
//
// Parametrised Fibonacci LFSR usable as an additive scrambler/PRBS source
// (ADD), a self-synchronous scrambler (MSCR) or descrambler (MDSC), or a
// PRBS checker with a saturating error counter (CHECK). LANES bits are
// processed per beat. Lane 0 is the oldest bit in time, so a beat is
// exactly LANES single-bit steps. The datapath is one valid/ready register
// stage.
//
// Ports
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset
//   mode        00 ADD, 01 MSCR, 10 MDSC, 11 CHECK (sampled per accepted beat)
//   in_valid    input beat valid
//   in_ready    input beat accepted when in_valid && in_ready
//   in_data     LANES input bits, bit 0 first
//   out_valid   output beat valid
//   out_ready   downstream accept
//   out_data    LANES output bits (error bits in CHECK mode)
//   seed_load   one-cycle pulse: load seed_value (SEED if zero) into the LFSR
//   seed_value  state to load
//   err_clear   synchronous clear of err_count (wins over an increment)
//   err_count   saturating count of mismatching bits seen in CHECK mode
// ---------------------------------------------------------------------------
module lfsr_scrambler_param #(
   parameter int unsigned      WIDTH = 12,
   parameter logic [WIDTH-1:0] TAPS  = 12'h829,
   parameter logic [WIDTH-1:0] SEED  = 12'h001,
   parameter int unsigned      LANES = 1,
   parameter int unsigned      CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [1:0]       mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [LANES-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [LANES-1:0] out_data,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_value,
   input  logic             err_clear,
   output logic [CNT_W-1:0] err_count
);

   localparam int unsigned PC_W  = $clog2(LANES + 1);
   localparam int unsigned SUM_W = CNT_W + PC_W;

   typedef enum logic [1:0] {
      MODE_ADD   = 2'b00,
      MODE_MSCR  = 2'b01,
      MODE_MDSC  = 2'b10,
      MODE_CHECK = 2'b11
   } mode_e;

   // Number of set bits in one beat.
   function automatic logic [PC_W-1:0] popcount(input logic [LANES-1:0] v);
      logic [PC_W-1:0] c;
      c = '0;
      for (int i = 0; i < LANES; i++) begin
         c = c + PC_W'(v[i]);
      end
      return c;
   endfunction

   // Add with saturation at all-ones; the sum is formed wide enough that it
   // can never overflow before the clamp.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [PC_W-1:0]  inc);
      logic [SUM_W-1:0] sum;
      sum = SUM_W'(a) + SUM_W'(inc);
      if (sum > SUM_W'({CNT_W{1'b1}})) begin
         return {CNT_W{1'b1}};
      end
      return sum[CNT_W-1:0];
   endfunction

   mode_e            mode_w;
   logic [WIDTH-1:0] state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [LANES-1:0] out_data_q, out_data_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic             accept;

   logic [WIDTH-1:0] walk_s;
   logic [LANES-1:0] walk_o;
   logic             fb, ob, bb;

   assign mode_w = mode_e'(mode);

   // A load cycle never accepts data, so the new state is not overwritten
   // by a beat in the same edge. Otherwise the stage is free when empty or
   // when its current beat leaves this cycle.
   assign in_ready = !seed_load && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   // Unroll LANES serial steps. walk_s is the state seen by the lane being
   // processed; after the loop it is the state after the whole beat.
   always_comb begin
      walk_s = state_q;
      walk_o = '0;
      fb     = 1'b0;
      ob     = 1'b0;
      bb     = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         fb = ^(walk_s & TAPS);
         case (mode_w)
            MODE_MSCR: begin
               ob = in_data[i] ^ fb;
               bb = ob;
            end
            MODE_MDSC: begin
               ob = in_data[i] ^ fb;
               bb = in_data[i];
            end
            default: begin
               // ADD and CHECK: free-running generator, data only masked.
               ob = in_data[i] ^ walk_s[0];
               bb = fb;
            end
         endcase
         walk_o[i] = ob;
         walk_s    = {bb, walk_s[WIDTH-1:1]};
      end
   end

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      err_d       = err_q;

      // An all-zero state would lock the generator, so zero falls back to SEED.
      if (seed_load) begin
         state_d = (seed_value == '0) ? SEED : seed_value;
      end else if (accept) begin
         state_d = walk_s;
      end

      // out_data only changes on a new beat, so it holds under backpressure
      // and is untouched by a seed load.
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = walk_o;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      if (err_clear) begin
         err_d = '0;
      end else if (accept && (mode_w == MODE_CHECK)) begin
         err_d = sat_add(err_q, popcount(walk_o));
      end
   end

   // Output register stage
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= SEED;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         err_q       <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         err_q       <= err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign err_count = err_q;

endmodule

// File: tb/tb_lfsr_scrambler_param.sv
module tb_lfsr_scrambler_param;

   localparam logic [11:0] TB_TAPS = 12'h829;
   localparam logic [11:0] TB_SEED = 12'h001;
   localparam logic [1:0]  M_ADD   = 2'b00;
   localparam logic [1:0]  M_MSCR  = 2'b01;
   localparam logic [1:0]  M_MDSC  = 2'b10;
   localparam logic [1:0]  M_CHECK = 2'b11;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [1:0]  mode;
   logic        in_valid;
   logic        out_ready;
   logic        seed_load;
   logic [11:0] seed_value;
   logic        err_clear;
   logic [0:0]  in_data1;
   logic [7:0]  in_data8;

   logic        in_ready1, in_ready8;
   logic        out_valid1, out_valid8;
   logic [0:0]  out_data1;
   logic [7:0]  out_data8;
   logic [15:0] err1;
   logic [3:0]  err8;

   int n_chk = 0;
   int n_err = 0;

   // Reference model state: plain bit vectors stepped by the textual rules.
   logic [11:0] m_s1, m_s8;
   int          m_err1, m_err8;
   logic        sb1[$];
   logic [7:0]  sb8[$];
   logic        log1[$];
   logic [7:0]  log8[$];
   logic        gen1[$];
   logic [7:0]  gen8[$];
   logic        rt_in[$];
   logic        scr[$];

   bit   bp_hold = 1'b0;
   bit   rand_bp = 1'b0;
   logic mon_e1;
   logic [7:0] mon_e8;

   lfsr_scrambler_param #(.WIDTH(12), .TAPS(12'h829), .SEED(12'h001), .LANES(1), .CNT_W(16)) dut1 (
      .clock(clock), .reset_n(reset_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready1),
      .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
      .seed_load(seed_load), .seed_value(seed_value), .err_clear(err_clear), .err_count(err1));

   lfsr_scrambler_param #(.WIDTH(12), .TAPS(12'h829), .SEED(12'h001), .LANES(8), .CNT_W(4)) dut8 (
      .clock(clock), .reset_n(reset_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready8),
      .in_data(in_data8), .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
      .seed_load(seed_load), .seed_value(seed_value), .err_clear(err_clear), .err_count(err8));

   initial forever #5 clock = ~clock;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // One serial step: returns {output bit, next state}.
   function automatic logic [12:0] step(input logic [11:0] s, input logic [1:0] md, input logic d);
      logic fb, o, b;
      fb = ^(s & TB_TAPS);
      case (md)
         M_MSCR:  begin o = d ^ fb;   b = o;  end
         M_MDSC:  begin o = d ^ fb;   b = d;  end
         default: begin o = d ^ s[0]; b = fb; end
      endcase
      return {o, b, s[11:1]};
   endfunction

   function automatic void model1(input logic [1:0] md, input logic d, input bit clr);
      logic [12:0] r;
      r = step(m_s1, md, d);
      m_s1 = r[11:0];
      sb1.push_back(r[12]);
      if (clr) m_err1 = 0;
      else if (md == M_CHECK) m_err1 = (m_err1 + int'(r[12]) > 65535) ? 65535 : m_err1 + int'(r[12]);
   endfunction

   function automatic void model8(input logic [1:0] md, input logic [7:0] d, input bit clr);
      logic [12:0] r;
      logic [7:0]  o;
      int          cnt;
      cnt = 0;
      o = '0;
      for (int i = 0; i < 8; i++) begin
         r = step(m_s8, md, d[i]);
         m_s8 = r[11:0];
         o[i] = r[12];
         cnt += int'(r[12]);
      end
      sb8.push_back(o);
      if (clr) m_err8 = 0;
      else if (md == M_CHECK) m_err8 = (m_err8 + cnt > 15) ? 15 : m_err8 + cnt;
   endfunction

   // Offer one beat to both instances; the model is updated for the edge at
   // which the beat is accepted.
   task automatic beat(input logic [1:0] md, input logic d1, input logic [7:0] d8, input bit clr);
      int  n;
      bit  done;
      n = 0;
      done = 1'b0;
      while (!done) begin
         @(negedge clock);
         in_valid = 1'b1; mode = md; in_data1 = d1; in_data8 = d8;
         err_clear = clr; seed_load = 1'b0;
         #1;
         if (in_ready1) begin
            model1(md, d1, clr);
            model8(md, d8, clr);
            done = 1'b1;
            @(posedge clock);
         end else begin
            n++;
            if (n > 200) begin
               n_chk++; n_err++;
               $display("FAIL beat_timeout: in_ready low for %0d cycles, expected high", n);
               in_valid = 1'b0;
               done = 1'b1;
            end
         end
      end
   endtask

   task automatic do_seed(input logic [11:0] v);
      @(negedge clock);
      in_valid = 1'b0; err_clear = 1'b0; seed_load = 1'b1; seed_value = v;
      #1;
      chk("seed_in_ready1", 64'(in_ready1), 64'(0));
      chk("seed_in_ready8", 64'(in_ready8), 64'(0));
      m_s1 = (v == 12'h000) ? TB_SEED : v;
      m_s8 = m_s1;
      @(posedge clock);
   endtask

   task automatic clear_err();
      @(negedge clock);
      in_valid = 1'b0; seed_load = 1'b0; err_clear = 1'b1;
      @(posedge clock);
      m_err1 = 0;
      m_err8 = 0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      rand_bp = 1'b0;
      while ((sb1.size() != 0 || sb8.size() != 0) && n < 100) begin
         @(negedge clock);
         in_valid = 1'b0; err_clear = 1'b0; seed_load = 1'b0;
         #2;
         n++;
      end
      if (sb1.size() != 0 || sb8.size() != 0) begin
         n_chk++; n_err++;
         $display("FAIL drain_timeout: %0d/%0d beats outstanding, expected 0", sb1.size(), sb8.size());
         sb1.delete();
         sb8.delete();
      end
   endtask

   // Downstream ready: held low on request, otherwise random or always high.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(negedge clock);
         if (bp_hold) out_ready = 1'b0;
         else if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
         else out_ready = 1'b1;
      end
   end

   // Monitor: every beat leaving the DUT is matched against the scoreboard.
   initial begin
      forever begin
         @(negedge clock);
         #1;
         if (reset_n && out_ready) begin
            if (out_valid1) begin
               if (sb1.size() == 0) begin
                  n_chk++; n_err++;
                  $display("FAIL out1_extra: got beat %0h, expected none", out_data1);
               end else begin
                  mon_e1 = sb1.pop_front();
                  chk("out1", 64'(out_data1), 64'(mon_e1));
                  log1.push_back(out_data1[0]);
               end
            end
            if (out_valid8) begin
               if (sb8.size() == 0) begin
                  n_chk++; n_err++;
                  $display("FAIL out8_extra: got beat %0h, expected none", out_data8);
               end else begin
                  mon_e8 = sb8.pop_front();
                  chk("out8", 64'(out_data8), 64'(mon_e8));
                  log8.push_back(out_data8);
               end
            end
         end
      end
   end

   initial begin
      int mism;
      logic d;
      reset_n = 1'b0; in_valid = 1'b0; mode = M_ADD; in_data1 = '0; in_data8 = '0;
      seed_load = 1'b0; seed_value = '0; err_clear = 1'b0;
      m_s1 = TB_SEED; m_s8 = TB_SEED; m_err1 = 0; m_err8 = 0;

      // Reset state
      repeat (3) @(negedge clock);
      #1;
      chk("rst_out_valid1", 64'(out_valid1), 64'(0));
      chk("rst_out_valid8", 64'(out_valid8), 64'(0));
      chk("rst_out_data1", 64'(out_data1), 64'(0));
      chk("rst_out_data8", 64'(out_data8), 64'(0));
      chk("rst_err1", 64'(err1), 64'(0));
      chk("rst_err8", 64'(err8), 64'(0));
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      chk("rst_in_ready1", 64'(in_ready1), 64'(1));

      // ADD generator from SEED with zero data
      for (int i = 0; i < 48; i++) beat(M_ADD, 1'b0, 8'h00, 1'b0);
      drain();
      gen1 = log1;
      gen8 = log8;
      chk("gen_len", 64'(gen1.size()), 64'(48));
      for (int i = 0; i < 13; i++)
         chk($sformatf("gen1[%0d]", i), 64'(gen1[i]), 64'((i == 0 || i == 12) ? 1 : 0));
      chk("gen8[0]", 64'(gen8[0]), 64'(8'h01));

      // CHECK: regenerate from SEED (zero seed_value falls back), 3 flips
      do_seed(12'h000);
      clear_err();
      for (int i = 0; i < 40; i++)
         beat(M_CHECK, gen1[i] ^ (i == 5 || i == 17 || i == 30), gen8[i], 1'b0);
      drain();
      chk("check_err1", 64'(err1), 64'(3));
      chk("check_err8", 64'(err8), 64'(0));
      beat(M_CHECK, ~gen1[40], ~gen8[40], 1'b1);
      drain();
      chk("clear_wins_err1", 64'(err1), 64'(0));
      chk("clear_wins_err8", 64'(err8), 64'(0));
      beat(M_CHECK, gen1[41], ~gen8[41], 1'b0);
      drain();
      chk("sat_step_err8", 64'(err8), 64'(8));
      beat(M_CHECK, gen1[42], ~gen8[42], 1'b0);
      beat(M_CHECK, gen1[43], ~gen8[43], 1'b0);
      drain();
      chk("sat_err8", 64'(err8), 64'(15));
      chk("sat_err1", 64'(err1), 64'(0));

      // Round trip MSCR -> MDSC with the same seed, then with another seed
      do_seed(12'hA5C);
      log1.delete(); log8.delete(); rt_in.delete();
      rand_bp = 1'b1;
      for (int i = 0; i < 4096; i++) begin
         d = 1'($urandom);
         rt_in.push_back(d);
         beat(M_MSCR, d, 8'($urandom), 1'b0);
      end
      drain();
      scr = log1;
      do_seed(12'hA5C);
      log1.delete();
      rand_bp = 1'b1;
      for (int i = 0; i < 4096; i++) beat(M_MDSC, scr[i], 8'($urandom), 1'b0);
      drain();
      chk("rt_len", 64'(log1.size()), 64'(4096));
      mism = 0;
      for (int i = 0; i < log1.size() && i < rt_in.size(); i++) if (log1[i] !== rt_in[i]) mism++;
      chk("rt_same_seed", 64'(mism), 64'(0));
      do_seed(12'h3F1);
      log1.delete();
      for (int i = 0; i < 256; i++) beat(M_MDSC, scr[i], 8'($urandom), 1'b0);
      drain();
      mism = 0;
      for (int i = 12; i < log1.size() && i < 256; i++) if (log1[i] !== rt_in[i]) mism++;
      chk("rt_other_seed", 64'(mism), 64'(0));

      // Random modes, data, backpressure and clears
      rand_bp = 1'b1;
      for (int i = 0; i < 1000; i++)
         beat(2'($urandom_range(0, 3)), 1'($urandom), 8'($urandom), ($urandom_range(0, 15) == 0));
      drain();
      chk("rand_err1", 64'(err1), 64'(m_err1));
      chk("rand_err8", 64'(err8), 64'(m_err8));

      // Backpressure: 5 cycles of out_ready low with a pending beat
      beat(M_MSCR, 1'($urandom), 8'($urandom), 1'b0);
      bp_hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         in_valid = 1'b1; mode = M_ADD; in_data1 = 1'($urandom); in_data8 = 8'($urandom);
         #1;
         chk("bp_in_ready1", 64'(in_ready1), 64'(0));
         chk("bp_in_ready8", 64'(in_ready8), 64'(0));
         chk("bp_out_valid1", 64'(out_valid1), 64'(1));
         chk("bp_hold_data1", 64'(out_data1), 64'(sb1[0]));
         chk("bp_hold_data8", 64'(out_data8), 64'(sb8[0]));
      end
      bp_hold = 1'b0;
      rand_bp = 1'b1;
      for (int i = 0; i < 20; i++) beat(M_ADD, 1'($urandom), 8'($urandom), 1'b0);
      drain();

      // Reset mid-stream with a pending beat
      beat(M_CHECK, 1'($urandom), 8'($urandom), 1'b0);
      bp_hold = 1'b1;
      @(negedge clock);
      in_valid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_out_valid1", 64'(out_valid1), 64'(0));
      chk("mid_rst_out_valid8", 64'(out_valid8), 64'(0));
      chk("mid_rst_err1", 64'(err1), 64'(0));
      chk("mid_rst_err8", 64'(err8), 64'(0));
      sb1.delete(); sb8.delete();
      m_s1 = TB_SEED; m_s8 = TB_SEED; m_err1 = 0; m_err8 = 0;
      @(negedge clock);
      reset_n = 1'b1;
      bp_hold = 1'b0;
      #1;
      chk("mid_rst_in_ready1", 64'(in_ready1), 64'(1));
      for (int i = 0; i < 20; i++) beat(M_ADD, 1'b0, 8'h00, 1'b0);
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/lfsr_scrambler_param.md
# lfsr_scrambler_param

Parametrised LFSR scrambler, descrambler, PRBS generator and checker. It generalises the fixed 12-bit, taps-6/4, 1-bit-per-clock LFSR stage to any width, any tap polynomial and LANES bits per clock. Mode is selectable at run time. Data moves through a valid/ready-handshaked single register stage. The block sits on the serial datapath between framing and line coding, or in a test harness as a PRBS source or sink.

## Interface
- WIDTH, 12: LFSR length in bits, 2..64.
- TAPS, 12'h829: feedback mask, WIDTH bits. Bit k set means s[k] enters the feedback XOR. Default is taps 0, 3, 5, 11.
- SEED, 12'h001: reset and fallback state. Must be non-zero.
- LANES, 1: data bits processed per beat, 1..64. Bit 0 is processed first.
- CNT_W, 16: error counter width.
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- mode  in  2  operating mode: 00 ADD, 01 MSCR, 10 MDSC, 11 CHECK. Sampled with each accepted beat.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  LANES  input bits.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  LANES  output bits.
- seed_load  in  1  one-cycle pulse that loads seed_value into the LFSR.
- seed_value  in  WIDTH  state to load.
- err_clear  in  1  synchronous clear of err_count.
- err_count  out  CNT_W  saturating mismatch count (CHECK mode only).

## Operation
- LFSR state s[WIDTH-1:0]. One step:
  - s'[i] = s[i+1] for i < WIDTH-1.
  - s'[WIDTH-1] = b, where b depends on mode.
  - fb = XOR of s[k] over all k set in TAPS.
- Per data bit d, steps are applied serially for lanes 0..LANES-1. Each beat is combinationally equivalent to LANES serial steps.
- ADD: o = d ^ s[0]; b = fb. State sequence is independent of the data.
- MSCR (self-synchronous scrambler): o = d ^ fb; b = o.
- MDSC (self-synchronous descrambler): o = d ^ fb; b = d. MDSC is the exact inverse of MSCR.
- CHECK: o = d ^ s[0] (error bits); b = fb.
  - err_count += popcount(o) per accepted beat.
  - err_count saturates at 2^CNT_W-1 and does not wrap.
- The state advances only on an accepted input beat. It holds otherwise.
- seed_load:
  - Next state = seed_value, or SEED if seed_value == 0.
  - in_ready is forced to 0 during the seed_load cycle, so a load and an acceptance never coincide.
- err_clear together with an increment in the same cycle: the clear wins, and the result is 0.
- A mode change between beats does not alter the state. There is no resynchronisation.

## Timing
- Reset, asynchronous:
  - s = SEED.
  - out_valid = 0, out_data = 0.
  - err_count = 0.
  - in_ready = 1 after reset release.
- Latency is 1 clock. A beat accepted at edge N appears on out_data/out_valid after edge N.
- in_ready = !seed_load && (!out_valid || out_ready). This gives full throughput of one beat per clock with no bubble.
- out_data and out_valid hold stable while out_valid && !out_ready.
- Reset asserted mid-stream drops any pending output beat. No partial beat survives.
- seed_load while out_valid is pending does not disturb out_data. The new state applies to the next accepted beat.

## Test plan
- **ADD, generator check:** WIDTH=12, LANES=1, SEED=001, in_data=0 for 13 beats -> out bits 1, then eleven 0s, then 1. Sequence period is 4095 beats.
- **LANES=8 equivalence:** same setup, one beat with in_data=00 -> out_data=01, with state equal to the LANES=1 model after 8 steps. Random data over 1000 beats matches the serial model bit-for-bit.
- **Round-trip:** MSCR instance feeds MDSC instance, same SEED, 4096 random beats -> MDSC output equals MSCR input. With mismatched seeds, outputs match from bit WIDTH onward.
- **CHECK mode:**
  - ADD output with in_data=0 looped into CHECK, with 3 single-bit flips injected -> err_count=3.
  - err_clear during an error beat -> 0.
  - Forced count at CNT_W max plus one more error -> stays at max.
- **Backpressure:** out_ready low for 5 cycles mid-stream -> in_ready low, out_data held, and no beats lost or duplicated against the model.
- **Load and reset:**
  - seed_load with seed_value=0 -> state=SEED, with in_ready=0 that cycle.
  - reset_n pulsed mid-stream -> out_valid=0 immediately, s=SEED, err_count=0.
